// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctrl_pkg : opcode constants, enums and decode record for ctrl_pipe    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] PCSRC_SEQ  = 2'd0;
  localparam logic [1:0] PCSRC_JAL  = 2'd1;
  localparam logic [1:0] PCSRC_JALR = 2'd2;

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_ADD   = 4'd3,
    ALU_SUB   = 4'd4,
    ALU_MUL   = 4'd5,
    ALU_MULH  = 4'd6,
    ALU_MULHU = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_SLT   = 4'd12,
    ALU_SLTU  = 4'd13
  } aluop_e;

  // Write-back source select: CSR read data, immediate, ALU result, PC+4.
  typedef enum logic [2:0] {
    RS_CSR = 3'd0,
    RS_IMM = 3'd1,
    RS_ALU = 3'd2,
    RS_PC4 = 3'd3
  } regsel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  typedef struct packed {
    logic       alusrc;
    logic       regwrite;
    regsel_e    regsel;
    aluop_e     aluop;
    logic [1:0] pcsrc;
    logic       gpio_we;
    logic       br;
    logic       illegal;
  } ctrl_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctrl_decode : combinational instruction decode for ctrl_pipe          |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       is_mul_o,
  output logic       is_jump_o
);

  logic  legal;
  ctrl_t c;

  always_comb begin
    c         = '0;
    legal     = 1'b0;
    is_mul_o  = 1'b0;
    is_jump_o = 1'b0;
    case (opcode_i)
      OPC_OP: begin
        c.regwrite = 1'b1;
        c.regsel   = RS_ALU;
        if (funct7_i == F7_MULDIV) begin
          // Only mul/mulh/mulhu exist here; other M encodings fall to illegal.
          legal    = 1'b1;
          is_mul_o = 1'b1;
          case (funct3_i)
            3'b000:  c.aluop = ALU_MUL;
            3'b001:  c.aluop = ALU_MULH;
            3'b011:  c.aluop = ALU_MULHU;
            default: legal = 1'b0;
          endcase
        end else if (funct7_i == F7_BASE) begin
          legal = 1'b1;
          case (funct3_i)
            3'b000:  c.aluop = ALU_ADD;
            3'b001:  c.aluop = ALU_SLL;
            3'b010:  c.aluop = ALU_SLT;
            3'b011:  c.aluop = ALU_SLTU;
            3'b100:  c.aluop = ALU_XOR;
            3'b101:  c.aluop = ALU_SRL;
            3'b110:  c.aluop = ALU_OR;
            default: c.aluop = ALU_AND;
          endcase
        end else if (funct7_i == F7_ALT) begin
          case (funct3_i)
            3'b000: begin legal = 1'b1; c.aluop = ALU_SUB; end
            3'b101: begin legal = 1'b1; c.aluop = ALU_SRA; end
            default: legal = 1'b0;
          endcase
        end
      end
      OPC_OPIMM: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.regsel   = RS_ALU;
        legal      = 1'b1;
        case (funct3_i)
          3'b000: c.aluop = ALU_ADD;
          3'b010: c.aluop = ALU_SLT;
          3'b011: c.aluop = ALU_SLTU;
          3'b100: c.aluop = ALU_XOR;
          3'b110: c.aluop = ALU_OR;
          3'b111: c.aluop = ALU_AND;
          3'b001: begin
            c.aluop = ALU_SLL;
            legal   = (funct7_i == F7_BASE);
          end
          default: begin
            legal = (funct7_i == F7_BASE) || (funct7_i == F7_ALT);
            if (funct7_i[5]) c.aluop = ALU_SRA;
            else             c.aluop = ALU_SRL;
          end
        endcase
      end
      OPC_LUI: begin
        legal      = 1'b1;
        c.regwrite = 1'b1;
        c.regsel   = RS_IMM;
      end
      OPC_JAL: begin
        legal      = 1'b1;
        is_jump_o  = 1'b1;
        c.regwrite = 1'b1;
        c.regsel   = RS_PC4;
        c.pcsrc    = PCSRC_JAL;
      end
      OPC_JALR: begin
        // Target is rs1 + imm, so the ALU adds with the immediate operand.
        legal      = (funct3_i == 3'b000);
        is_jump_o  = 1'b1;
        c.regwrite = 1'b1;
        c.regsel   = RS_PC4;
        c.pcsrc    = PCSRC_JALR;
        c.alusrc   = 1'b1;
        c.aluop    = ALU_ADD;
      end
      OPC_BRANCH: begin
        legal   = (funct3_i != 3'b010) && (funct3_i != 3'b011);
        c.br    = 1'b1;
        c.aluop = ALU_SUB;
      end
      OPC_SYSTEM: begin
        legal      = (funct3_i == 3'b001);
        c.gpio_we  = 1'b1;
        c.regwrite = 1'b1;
        c.regsel   = RS_CSR;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      c         = '0;
      c.illegal = 1'b1;
      is_mul_o  = 1'b0;
      is_jump_o = 1'b0;
    end
  end

  assign ctrl_o = c;

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctrl_pipe : registered control decode with multiply stall and flush   |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MUL_CYCLES   = 3,
  parameter int ALUOP_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [11:0]        csr,
  input  logic               br_taken,
  output logic               out_valid,
  output logic               alusrc,
  output logic               regwrite,
  output logic [2:0]         regsel,
  output logic [ALUOP_W-1:0] aluop,
  output logic [1:0]         pcsrc,
  output logic               gpio_we,
  output logic               br,
  output logic               illegal,
  output logic               stall_fetch
);

  localparam int CNT_MAX = max_int(FLUSH_CYCLES, MUL_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            hold_q, hold_d;
  ctrl_t            out_q, out_d;
  logic             out_valid_q, out_valid_d;

  ctrl_t dec_ctrl;
  logic  dec_is_mul;
  logic  dec_is_jump;
  logic  accept;
  logic  unused_csr;

  assign unused_csr = ^csr;

  ctrl_decode u_decode (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .funct7_i  (funct7),
    .ctrl_o    (dec_ctrl),
    .is_mul_o  (dec_is_mul),
    .is_jump_o (dec_is_jump)
  );

  assign accept = in_valid && (state_q != ST_MUL_BUSY);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    out_valid_d = 1'b0;
    out_d       = '0;
    case (state_q)
      ST_RUN: begin
        if (br_taken) begin
          // A resolved branch squashes whatever is being offered this cycle.
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end else if (accept) begin
          if (dec_is_mul) begin
            state_d = ST_MUL_BUSY;
            cnt_d   = CNT_W'(MUL_CYCLES - 1);
            hold_d  = dec_ctrl;
          end else begin
            out_valid_d = 1'b1;
            out_d       = dec_ctrl;
            if (dec_is_jump) begin
              state_d = ST_FLUSH;
              cnt_d   = CNT_W'(FLUSH_CYCLES);
            end
          end
        end
      end
      ST_MUL_BUSY: begin
        if (br_taken) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES);
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_d       = hold_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (br_taken) begin
          cnt_d = CNT_W'(FLUSH_CYCLES);
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      hold_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Gated by rst so the handshake is closed for the whole reset window.
  assign in_ready    = !rst && (state_q != ST_MUL_BUSY);
  assign stall_fetch = (state_q != ST_RUN);

  assign out_valid = out_valid_q;
  assign alusrc    = out_q.alusrc;
  assign regwrite  = out_q.regwrite;
  assign regsel    = out_q.regsel;
  assign aluop     = ALUOP_W'(out_q.aluop);
  assign pcsrc     = out_q.pcsrc;
  assign gpio_we   = out_q.gpio_we;
  assign br        = out_q.br;
  assign illegal   = out_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ctrl_pipe : directed vector bench for ctrl_pipe                    |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [11:0] csr;
  logic       br_taken;
  logic       out_valid;
  logic       alusrc;
  logic       regwrite;
  logic [2:0] regsel;
  logic [3:0] aluop;
  logic [1:0] pcsrc;
  logic       gpio_we;
  logic       br;
  logic       illegal;
  logic       stall_fetch;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(
    .FLUSH_CYCLES (2),
    .MUL_CYCLES   (3),
    .ALUOP_W      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .csr         (csr),
    .br_taken    (br_taken),
    .out_valid   (out_valid),
    .alusrc      (alusrc),
    .regwrite    (regwrite),
    .regsel      (regsel),
    .aluop       (aluop),
    .pcsrc       (pcsrc),
    .gpio_we     (gpio_we),
    .br          (br),
    .illegal     (illegal),
    .stall_fetch (stall_fetch)
  );

  // {out_valid, alusrc, regwrite, regsel, aluop, pcsrc, gpio_we, br, illegal}
  function automatic logic [14:0] pk(input logic ov, input logic as, input logic rw,
                                     input logic [2:0] rs, input logic [3:0] alu,
                                     input logic [1:0] pc, input logic g,
                                     input logic b, input logic il);
    return {ov, as, rw, rs, alu, pc, g, b, il};
  endfunction

  logic [14:0] obs;
  assign obs = {out_valid, alusrc, regwrite, regsel, aluop, pcsrc, gpio_we, br, illegal};

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [14:0] exp;
  } vec_t;

  vec_t v[20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic offer(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    opcode   = o;
    funct3   = f3;
    funct7   = f7;
    in_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // expected fields: ov, alusrc, regwrite, regsel, aluop, pcsrc, gpio_we, br, illegal
    v[0]  = '{7'b0110011, 3'b000, 7'b0000000, pk(1,0,1,3'd2,4'd3, 2'd0,0,0,0)}; // add
    v[1]  = '{7'b0110011, 3'b000, 7'b0100000, pk(1,0,1,3'd2,4'd4, 2'd0,0,0,0)}; // sub
    v[2]  = '{7'b0110011, 3'b101, 7'b0100000, pk(1,0,1,3'd2,4'd10,2'd0,0,0,0)}; // sra
    v[3]  = '{7'b0110011, 3'b011, 7'b0000000, pk(1,0,1,3'd2,4'd13,2'd0,0,0,0)}; // sltu
    v[4]  = '{7'b0110011, 3'b111, 7'b0000000, pk(1,0,1,3'd2,4'd0, 2'd0,0,0,0)}; // and
    v[5]  = '{7'b0110011, 3'b010, 7'b0000000, pk(1,0,1,3'd2,4'd12,2'd0,0,0,0)}; // slt
    v[6]  = '{7'b0010011, 3'b000, 7'b0000000, pk(1,1,1,3'd2,4'd3, 2'd0,0,0,0)}; // addi
    v[7]  = '{7'b0010011, 3'b101, 7'b0100000, pk(1,1,1,3'd2,4'd10,2'd0,0,0,0)}; // srai
    v[8]  = '{7'b0010011, 3'b101, 7'b0000000, pk(1,1,1,3'd2,4'd9, 2'd0,0,0,0)}; // srli
    v[9]  = '{7'b0010011, 3'b001, 7'b0000000, pk(1,1,1,3'd2,4'd8, 2'd0,0,0,0)}; // slli
    v[10] = '{7'b0010011, 3'b100, 7'b0000000, pk(1,1,1,3'd2,4'd2, 2'd0,0,0,0)}; // xori
    v[11] = '{7'b0010011, 3'b110, 7'b0000000, pk(1,1,1,3'd2,4'd1, 2'd0,0,0,0)}; // ori
    v[12] = '{7'b0110111, 3'b000, 7'b0000000, pk(1,0,1,3'd1,4'd0, 2'd0,0,0,0)}; // lui
    v[13] = '{7'b1100011, 3'b000, 7'b0000000, pk(1,0,0,3'd0,4'd4, 2'd0,0,1,0)}; // beq
    v[14] = '{7'b1110011, 3'b001, 7'b0000000, pk(1,0,1,3'd0,4'd0, 2'd0,1,0,0)}; // csrrw
    v[15] = '{7'b1101111, 3'b000, 7'b0000000, pk(1,0,1,3'd3,4'd0, 2'd1,0,0,0)}; // jal
    v[16] = '{7'b1100111, 3'b000, 7'b0000000, pk(1,1,1,3'd3,4'd3, 2'd2,0,0,0)}; // jalr
    v[17] = '{7'b0000000, 3'b000, 7'b0000000, pk(1,0,0,3'd0,4'd0, 2'd0,0,0,1)}; // bad opcode
    v[18] = '{7'b0110011, 3'b000, 7'b0000010, pk(1,0,0,3'd0,4'd0, 2'd0,0,0,1)}; // bad funct7
    v[19] = '{7'b1100011, 3'b010, 7'b0000000, pk(1,0,0,3'd0,4'd0, 2'd0,0,0,1)}; // bad branch

    rst = 1'b1; in_valid = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
    csr = 12'h7c0; br_taken = 1'b0;

    // Reset state
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_outputs", 32'(obs), 0);
    chk("rst_stall", 32'(stall_fetch), 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(in_ready), 1);

    // Table-driven decode
    for (int i = 0; i < 20; i++) begin
      int n;
      offer(v[i].opc, v[i].f3, v[i].f7);
      step();
      chk($sformatf("vec%0d", i), 32'(obs), 32'(v[i].exp));
      in_valid = 1'b0;
      n = 0;
      while (stall_fetch && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("vec%0d_drain", i), 32'(stall_fetch), 0);
    end
    step();

    // mul latency: in_ready low two cycles, result in the third
    offer(7'b0110011, 3'b000, 7'b0000001);
    step();
    chk("mul_c1_ready", 32'(in_ready), 0);
    chk("mul_c1_valid", 32'(out_valid), 0);
    chk("mul_c1_stall", 32'(stall_fetch), 1);
    offer(7'b0110011, 3'b000, 7'b0000000);
    step();
    chk("mul_c2_ready", 32'(in_ready), 0);
    chk("mul_c2_valid", 32'(out_valid), 0);
    step();
    chk("mul_c3_out", 32'(obs), 32'(pk(1,0,1,3'd2,4'd5,2'd0,0,0,0)));
    chk("mul_c3_ready", 32'(in_ready), 1);
    in_valid = 1'b0;
    step();
    chk("mul_c4_valid", 32'(out_valid), 0);

    // jal then flush window drops offered instructions
    offer(7'b1101111, 3'b000, 7'b0000000);
    step();
    chk("jal_out", 32'(obs), 32'(pk(1,0,1,3'd3,4'd0,2'd1,0,0,0)));
    chk("jal_f1_stall", 32'(stall_fetch), 1);
    offer(7'b0110011, 3'b000, 7'b0000000);
    step();
    chk("jal_f2_valid", 32'(out_valid), 0);
    chk("jal_f2_stall", 32'(stall_fetch), 1);
    step();
    chk("jal_f3_valid", 32'(out_valid), 0);
    chk("jal_f3_stall", 32'(stall_fetch), 0);
    step();
    chk("jal_after_add", 32'(obs), 32'(pk(1,0,1,3'd2,4'd3,2'd0,0,0,0)));
    in_valid = 1'b0;
    step();

    // br_taken beats a valid addi; br_taken in FLUSH reloads the counter
    offer(7'b0010011, 3'b000, 7'b0000000);
    br_taken = 1'b1;
    step();
    chk("brw_valid", 32'(out_valid), 0);
    chk("brw_stall", 32'(stall_fetch), 1);
    in_valid = 1'b0;
    step();
    br_taken = 1'b0;
    chk("brw_reload_stall0", 32'(stall_fetch), 1);
    step();
    chk("brw_reload_stall1", 32'(stall_fetch), 1);
    step();
    chk("brw_reload_end", 32'(stall_fetch), 0);
    chk("brw_reload_valid", 32'(out_valid), 0);

    // br_taken during MUL_BUSY aborts the multiply
    offer(7'b0110011, 3'b011, 7'b0000001);
    step();
    in_valid = 1'b0;
    br_taken = 1'b1;
    step();
    br_taken = 1'b0;
    chk("mabort_ready", 32'(in_ready), 1);
    chk("mabort_stall", 32'(stall_fetch), 1);
    chk("mabort_v1", 32'(out_valid), 0);
    step();
    chk("mabort_v2", 32'(out_valid), 0);
    step();
    chk("mabort_v3", 32'(out_valid), 0);
    chk("mabort_end", 32'(stall_fetch), 0);

    // reset in the second MUL_BUSY cycle
    offer(7'b0110011, 3'b000, 7'b0000001);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("mrst_ready_inrst", 32'(in_ready), 0);
    chk("mrst_valid_inrst", 32'(out_valid), 0);
    rst = 1'b0;
    #1;
    chk("mrst_ready", 32'(in_ready), 1);
    chk("mrst_stall", 32'(stall_fetch), 0);
    step();
    chk("mrst_no_pulse", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter: FLUSH_CYCLES, 2, bubble cycles inserted after a redirect (jal, jalr, taken branch); legal range 1..7.
REQ-002 Parameter: MUL_CYCLES, 3, total decode-to-out_valid latency for M-extension ops; legal range 2..15.
REQ-003 Parameter: ALUOP_W, 4, aluop width.
REQ-004 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Ports: in_valid  in  1, in_ready  out  1; instruction handshake, accepted when both are high.
REQ-007 Ports: opcode  in  7; funct3  in  3; funct7  in  7; csr  in  12.
REQ-008 Port: br_taken  in  1  single-cycle pulse from EX indicating a resolved taken branch.
REQ-009 Ports: out_valid  out  1; alusrc  out  1; regwrite  out  1; regsel  out  3; aluop  out  ALUOP_W; pcsrc  out  2; gpio_we  out  1; br  out  1; illegal  out  1.
REQ-010 Port: stall_fetch  out  1  high while the block is in FLUSH or MUL_BUSY.

Function
REQ-011 All outputs SHALL be registered; a non-M instruction accepted in cycle N SHALL appear, with out_valid=1, in cycle N+1 only.
REQ-012 Decode SHALL match the existing table: R-type 0110011 (regsel=2); I-type 0010011 (alusrc=1, regsel=2); lui 0110111 (regsel=1); jal (regsel=3, pcsrc=1); jalr (regsel=3, pcsrc=2); branch 1100011 (br=1, aluop=sub); csrrw 1110011/001 (gpio_we=1, regwrite=1).
REQ-013 aluop codes: and 0, or 1, xor 2, add 3, sub 4, mul 5, mulh 6, mulhu 7, sll 8, srl 9, sra 10, slt 12, sltu 13.
REQ-014 srli/srai SHALL be distinguished by funct7[5] (0 -> srl, 1 -> sra).
REQ-015 Any unlisted opcode/funct combination SHALL produce out_valid=1, illegal=1, and all write enables, pcsrc and br at 0.
REQ-016 Output fields SHALL be 0 whenever out_valid=0.
REQ-017 The FSM SHALL have three states: RUN, MUL_BUSY and FLUSH.
REQ-018 RUN: in_ready=1; accepting an M op (funct7=0000001) SHALL enter MUL_BUSY and load the counter with MUL_CYCLES-1.
REQ-019 MUL_BUSY: in_ready=0; the counter SHALL decrement each cycle; on the cycle it reaches 0 the block SHALL present the M op with out_valid=1 and return to RUN.
REQ-020 Accepting jal or jalr, or sampling br_taken=1 in RUN, SHALL enter FLUSH and load the counter with FLUSH_CYCLES.
REQ-021 FLUSH: in_ready=1; accepted instructions SHALL be discarded with out_valid=0; the counter SHALL decrement, and the block SHALL return to RUN in the cycle after the counter reaches 1.
REQ-022 br_taken together with a valid instruction in RUN: the branch SHALL win, the instruction SHALL be dropped, and the block SHALL enter FLUSH.
REQ-023 br_taken in MUL_BUSY SHALL abort the M op (no out_valid) and enter FLUSH; br_taken in FLUSH SHALL reload the counter with FLUSH_CYCLES.
REQ-024 The jal/jalr instruction itself SHALL still be emitted with out_valid=1 one cycle after acceptance.

Reset
REQ-025 While rst=1 the block SHALL be in state RUN with the counter at 0 and all outputs at 0, except in_ready=0.
REQ-026 Reset asserted mid-MUL_BUSY or mid-FLUSH SHALL abandon the operation with no out_valid pulse; in_ready SHALL be 1 in the first cycle after rst falls.

Structure
REQ-027 Package ctrl_pkg SHALL hold the opcode constants, the aluop enum, the regsel enum and the FSM state enum.
REQ-028 Combinational decode SHALL live in a sub-module ctrl_decode; ctrl_pipe SHALL contain the FSM, the counter and the output registers.
REQ-029 The counter width SHALL be derived from max(FLUSH_CYCLES, MUL_CYCLES).

Verification
REQ-030 add (0110011/000/0000000) accepted in cycle 5 -> cycle 6: out_valid=1, aluop=3, regsel=2, regwrite=1.
REQ-031 mul with MUL_CYCLES=3 accepted in cycle 10 -> in_ready=0 in cycles 11-12; out_valid=1 with aluop=5 in cycle 13 only.
REQ-032 jal accepted in cycle 4 with FLUSH_CYCLES=2 -> cycle 5: pcsrc=1, regsel=3; instructions offered in cycles 5-6 dropped; stall_fetch=1 in cycles 5-6.
REQ-033 br_taken and a valid addi in the same cycle -> no output for the addi; FLUSH entered.
REQ-034 srai (funct3=101, funct7=0100000) -> aluop=10; opcode 0000000 -> illegal=1, regwrite=0.
REQ-035 rst pulsed in the 2nd MUL_BUSY cycle -> no out_valid pulse; in_ready=1 in the cycle after rst falls.
